// File: rtl/ctrl_pipe.sv
// Registered control decoder with multi-cycle load sequencing.
// Decodes one instruction per cycle and stalls fetch while a load completes.
module ctrl_pipe #(
  parameter int IW       = 9,
  parameter int AW       = 3,
  parameter int LOAD_LAT = 1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [IW-1:0] Instruction,
  input  logic          Instr_valid,
  input  logic          Flush,
  output logic          Stall,
  output logic          Valid_out,
  output logic          Reg_write_en,
  output logic          Immediate_en,
  output logic          Data_write_en,
  output logic          Data_read_en,
  output logic          Data_select,
  output logic [AW-1:0] Reg_write_address,
  output logic [AW-1:0] Reg_read_address_0,
  output logic [AW-1:0] Reg_read_address_1,
  output logic [AW-1:0] Immediate
);

  localparam int CW = $clog2(LOAD_LAT) + 1;

  typedef enum logic {RUN, LWAIT} state_t;

  typedef struct packed {
    logic          valid;
    logic          rwe;
    logic          ie;
    logic          dwe;
    logic          dre;
    logic          dsel;
    logic [AW-1:0] wa;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic [AW-1:0] imm;
  } ctl_t;

  logic          cls;
  logic [1:0]    op;
  logic [AW-1:0] rs;
  logic [AW-1:0] rd;

  assign cls = Instruction[IW-1];
  assign op  = Instruction[IW-2:IW-3];
  assign rs  = Instruction[2*AW-1:AW];
  assign rd  = Instruction[AW-1:0];

  ctl_t dec;
  logic is_load;

  always_comb begin
    dec       = '0;
    is_load   = 1'b0;
    dec.valid = 1'b1;
    dec.imm   = rd;
    if (cls) begin
      case (op)
        2'b00, 2'b01: begin
          dec.rwe = 1'b1;
          dec.ra1 = rs;
          dec.wa  = rd;
        end
        2'b10: begin
          dec.dre  = 1'b1;
          dec.dsel = 1'b1;
          dec.wa   = rs;
          dec.ra0  = rd;
          dec.rwe  = (LOAD_LAT == 1);
          is_load  = 1'b1;
        end
        default: begin
          dec.dwe = 1'b1;
          dec.ra0 = rd;
          dec.ra1 = rs;
        end
      endcase
    end else begin
      dec.ra1 = AW'(1);
      dec.wa  = AW'(2);
      dec.ie  = Instruction[IW-2];
    end
  end

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  ctl_t          ctl, ctl_nx;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= RUN;
      cnt   <= '0;
      ctl   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      ctl   <= ctl_nx;
    end
  end

  // Flush overrides both decode and an outstanding load.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ctl_nx   = ctl;
    if (Flush) begin
      state_nx = RUN;
      cnt_nx   = '0;
      ctl_nx   = '0;
    end else begin
      case (state)
        RUN: begin
          if (Instr_valid) begin
            ctl_nx = dec;
            if (is_load && (LOAD_LAT > 1)) begin
              cnt_nx   = CW'(LOAD_LAT - 1);
              state_nx = LWAIT;
            end
          end else begin
            ctl_nx = '0;
          end
        end
        LWAIT: begin
          cnt_nx = cnt - CW'(1);
          if (cnt == CW'(1)) begin
            ctl_nx.rwe = 1'b1;
            state_nx   = RUN;
          end
        end
        default: begin
          state_nx = RUN;
          cnt_nx   = '0;
          ctl_nx   = '0;
        end
      endcase
    end
  end

  assign Stall              = (state == LWAIT);
  assign Valid_out          = ctl.valid;
  assign Reg_write_en       = ctl.rwe;
  assign Immediate_en       = ctl.ie;
  assign Data_write_en      = ctl.dwe;
  assign Data_read_en       = ctl.dre;
  assign Data_select        = ctl.dsel;
  assign Reg_write_address  = ctl.wa;
  assign Reg_read_address_0 = ctl.ra0;
  assign Reg_read_address_1 = ctl.ra1;
  assign Immediate          = ctl.imm;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: three instances (LOAD_LAT 1, 3, 4) on shared stimulus,
// checked every cycle against a cycle-schedule model plus literal pins.
module tb_ctrl_pipe;

  typedef struct packed {
    logic       v;
    logic       rwe;
    logic       ie;
    logic       dwe;
    logic       dre;
    logic       dsel;
    logic [2:0] wa;
    logic [2:0] ra0;
    logic [2:0] ra1;
    logic [2:0] imm;
  } ctl_t;

  logic       clk = 1'b0;
  logic       Reset = 1'b0;
  logic [8:0] Instruction = '0;
  logic       Instr_valid = 1'b0;
  logic       Flush = 1'b0;

  logic [2:0] v, rwe, ie, dwe, dre, dsel, stl;
  logic [2:0] wa [3];
  logic [2:0] ra0 [3];
  logic [2:0] ra1 [3];
  logic [2:0] imm [3];
  ctl_t       act [3];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ctrl_pipe #(
      .IW(9), .AW(3), .LOAD_LAT(g == 0 ? 1 : g + 2)
    ) u (
      .Clk(clk),
      .Reset(Reset),
      .Instruction(Instruction),
      .Instr_valid(Instr_valid),
      .Flush(Flush),
      .Stall(stl[g]),
      .Valid_out(v[g]),
      .Reg_write_en(rwe[g]),
      .Immediate_en(ie[g]),
      .Data_write_en(dwe[g]),
      .Data_read_en(dre[g]),
      .Data_select(dsel[g]),
      .Reg_write_address(wa[g]),
      .Reg_read_address_0(ra0[g]),
      .Reg_read_address_1(ra1[g]),
      .Immediate(imm[g])
    );
    assign act[g] = {v[g], rwe[g], ie[g], dwe[g], dre[g], dsel[g],
                     wa[g], ra0[g], ra1[g], imm[g]};
  end

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : i + 2;
  endfunction

  function automatic ctl_t mk(input bit vv, input bit w, input bit ii,
                              input bit dw, input bit dr, input bit ds,
                              input int a_w, input int a0, input int a1,
                              input int im);
    ctl_t c;
    c = {vv, w, ii, dw, dr, ds, 3'(a_w), 3'(a0), 3'(a1), 3'(im)};
    return c;
  endfunction

  function automatic bit is_ld(input logic [8:0] in);
    return in[8] && (in[7:6] == 2'b10);
  endfunction

  // Control values an instruction should produce, loads with final write.
  function automatic ctl_t decode(input logic [8:0] in);
    logic [2:0] rs, rd;
    rs = in[5:3];
    rd = in[2:0];
    if (!in[8])
      return mk(1, 0, in[7], 0, 0, 0, 2, 0, 1, int'(rd));
    case (in[7:6])
      2'b00, 2'b01: return mk(1, 1, 0, 0, 0, 0, int'(rd), 0, int'(rs), int'(rd));
      2'b10:        return mk(1, 1, 0, 0, 1, 1, int'(rs), int'(rd), 0, int'(rd));
      default:      return mk(1, 0, 0, 1, 0, 0, 0, int'(rd), int'(rs), int'(rd));
    endcase
  endfunction

  ctl_t exp_c [3];
  bit   busy  [3];
  int   done_e [3];
  int   edge_n = 0;

  // Model: a load accepted at edge e occupies the output until edge e+LAT-1.
  always @(posedge clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 3; i++) begin
        exp_c[i] <= '0;
        busy[i]  <= 1'b0;
      end
    end else begin
      edge_n <= edge_n + 1;
      for (int i = 0; i < 3; i++) begin
        automatic ctl_t c = exp_c[i];
        automatic bit   b = busy[i];
        automatic int   d = done_e[i];
        automatic int   e = edge_n + 1;
        if (Flush) begin
          c = '0;
          b = 1'b0;
        end else if (b) begin
          if (e == d) begin
            c.rwe = 1'b1;
            b     = 1'b0;
          end
        end else if (Instr_valid) begin
          c = decode(Instruction);
          if (is_ld(Instruction) && lat_of(i) > 1) begin
            c.rwe = 1'b0;
            b     = 1'b1;
            d     = e + lat_of(i) - 1;
          end
        end else begin
          c = '0;
        end
        exp_c[i]  <= c;
        busy[i]   <= b;
        done_e[i] <= d;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (act[i] !== exp_c[i] || stl[i] !== busy[i]) begin
          n_fail++;
          $display("FAIL cycle_cmp lat=%0d t=%0t dut=%h stall=%b want=%h stall=%b",
                   lat_of(i), $time, act[i], stl[i], exp_c[i], busy[i]);
        end
      end
    end
  end

  task automatic lit(input string nm, input int i, input ctl_t e, input bit es);
    n_tests++;
    if (act[i] !== e || stl[i] !== es) begin
      n_fail++;
      $display("FAIL %s lat=%0d dut=%h stall=%b want=%h stall=%b",
               nm, lat_of(i), act[i], stl[i], e, es);
    end
    n_tests++;
    if (exp_c[i] !== e || busy[i] !== es) begin
      n_fail++;
      $display("FAIL %s_model lat=%0d model=%h stall=%b want=%h stall=%b",
               nm, lat_of(i), exp_c[i], busy[i], e, es);
    end
  endtask

  task automatic lit_all(input string nm, input ctl_t e, input bit es);
    for (int i = 0; i < 3; i++) lit(nm, i, e, es);
  endtask

  task automatic cyc(input logic [8:0] ins, input bit val, input bit fl);
    Instruction = ins;
    Instr_valid = val;
    Flush       = fl;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  localparam logic [8:0] MOVE = 9'b1_00_101_011;
  localparam logic [8:0] ALUI = 9'b0_1_0000_110;
  localparam logic [8:0] LOAD = 9'b1_10_100_010;
  localparam logic [8:0] STOR = 9'b1_11_001_111;
  localparam logic [8:0] FLAG = 9'b1_01_110_001;

  localparam logic [10:0] TV [12] = '{
    {9'b1_01_110_001, 1'b1, 1'b0},
    {9'b0_0_1111_000, 1'b1, 1'b0},
    {9'b1_10_011_101, 1'b1, 1'b0},
    {9'b1_10_110_100, 1'b1, 1'b0},
    {9'b1_10_110_100, 1'b1, 1'b0},
    {9'b1_11_010_011, 1'b1, 1'b0},
    {9'b0_1_1010_111, 1'b1, 1'b0},
    {9'b0_0_0000_000, 1'b0, 1'b0},
    {9'b1_10_001_001, 1'b1, 1'b0},
    {9'b0_1_0000_001, 1'b1, 1'b1},
    {9'b1_00_111_111, 1'b1, 1'b0},
    {9'b0_0_0000_000, 1'b0, 1'b0}
  };

  ctl_t z, mv, ld1, ldw, ldr, st;

  initial begin
    z   = '0;
    mv  = mk(1, 1, 0, 0, 0, 0, 3, 0, 5, 3);
    ld1 = mk(1, 1, 0, 0, 1, 1, 4, 2, 0, 2);
    ldw = mk(1, 0, 0, 0, 1, 1, 4, 2, 0, 2);
    ldr = ld1;
    st  = mk(1, 0, 0, 1, 0, 0, 0, 7, 1, 7);

    // asynchronous reset mid-cycle with a valid instruction present
    #7;
    Instruction = 9'h1AB;
    Instr_valid = 1'b1;
    Reset = 1'b1;
    #1;
    chk_en = 1'b1;
    lit_all("reset_async", z, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    Reset = 1'b0;
    cyc(9'h0, 0, 0);
    cyc(9'h0, 0, 0);
    lit_all("reset_hold", z, 0);

    cyc(MOVE, 1, 0);
    lit_all("move", mv, 0);
    cyc(ALUI, 1, 0);
    lit_all("alu_imm", mk(1, 0, 1, 0, 0, 0, 2, 0, 1, 6), 0);
    cyc(9'h0, 0, 0);
    lit_all("bubble", z, 0);

    // multi-cycle load with a store waiting behind it
    cyc(LOAD, 1, 0);
    lit("load_k", 0, ld1, 0);
    lit("load_k", 1, ldw, 1);
    lit("load_k", 2, ldw, 1);
    cyc(STOR, 1, 0);
    lit("load_k1", 0, st, 0);
    lit("load_k1", 1, ldw, 1);
    lit("load_k1", 2, ldw, 1);
    cyc(STOR, 1, 0);
    lit("load_k2", 1, ldr, 0);
    lit("load_k2", 2, ldw, 1);
    cyc(STOR, 1, 0);
    lit("store_k3", 1, st, 0);
    lit("load_k3", 2, ldr, 0);
    cyc(9'h0, 0, 0);
    lit_all("idle_after_load", z, 0);

    // flush one edge into a load
    cyc(LOAD, 1, 0);
    lit("flush_pre", 2, ldw, 1);
    cyc(STOR, 1, 1);
    lit_all("flush_clear", z, 0);
    repeat (3) cyc(9'h0, 0, 0);
    lit("flush_no_rwe", 2, z, 0);
    cyc(MOVE, 1, 0);
    lit_all("move_after_flush", mv, 0);

    // reset pulse during a load
    cyc(LOAD, 1, 0);
    lit("rst_pre", 1, ldw, 1);
    Reset = 1'b1;
    #1;
    lit_all("reset_mid_load", z, 0);
    Reset = 1'b0;
    Instr_valid = 1'b0;
    cyc(MOVE, 1, 0);
    lit_all("move_after_reset", mv, 0);
    cyc(FLAG, 1, 0);
    lit_all("flag", mk(1, 1, 0, 0, 0, 0, 1, 0, 6, 1), 0);

    // mixed stream incl. back-to-back loads and a flush
    for (int t = 0; t < 12; t++) begin
      logic [10:0] vec;
      vec = TV[t];
      cyc(vec[10:2], vec[1], vec[0]);
    end
    repeat (6) cyc(9'h0, 0, 0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
